// File: rtl/q_pkg.sv
// ============================================================================
// Module : q_pkg
// Brief  : Shared definitions for the Q-learning update stage and the
//          max-Q/reward stage: table geometry, fixed-point widths, value
//          types, the update FSM state encoding and overflow-aware
//          add/subtract helpers.
// Config : QUPD_SATURATE_EN defined -> QW-bit results clamp on overflow,
//          otherwise they wrap modulo 2^QW.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package q_pkg;

  localparam int N_STATES  = 36;
  localparam int N_ACTIONS = 4;
  localparam int QW        = 32;
  localparam int FRAC      = 16;
  localparam int CW        = 16;

  // Reward for reaching the goal, and the goal cell of the 6x6 maze.
  localparam int REWARD_GOAL = 10;
  localparam int GOAL_STATE  = 35;
  localparam int GOAL_ROW    = 5;
  localparam int GOAL_COL    = 5;

  typedef logic signed [QW-1:0] q_t;
  typedef logic [CW-1:0]        coef_t;

  localparam q_t Q_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam q_t Q_MIN = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_TD    = 3'd2,
    ST_DELTA = 3'd3,
    ST_SCALE = 3'd4,
    ST_WRITE = 3'd5
  } q_state_e;

  // Signed add; overflow only possible when both operands share a sign.
  function automatic q_t q_add(input q_t a, input q_t b);
    q_t s;
    s = a + b;
`ifdef QUPD_SATURATE_EN
    if ((a[QW-1] == b[QW-1]) && (s[QW-1] != a[QW-1]))
      s = a[QW-1] ? Q_MIN : Q_MAX;
`endif
    return s;
  endfunction

  // Signed subtract; overflow only possible when operand signs differ.
  function automatic q_t q_sub(input q_t a, input q_t b);
    q_t s;
    s = a - b;
`ifdef QUPD_SATURATE_EN
    if ((a[QW-1] != b[QW-1]) && (s[QW-1] != a[QW-1]))
      s = a[QW-1] ? Q_MIN : Q_MAX;
`endif
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/q_fx_mul.sv
// ============================================================================
// Module : q_fx_mul
// Brief  : Combinational signed Q16.16 x unsigned UQ0.16 multiply. The
//          (QW+CW)-bit product is arithmetically shifted right by FRAC
//          (floor toward -inf) and reduced to QW bits.
// Ports  : i_x    - signed QW-bit operand
//          i_coef - unsigned CW-bit fractional coefficient
//          o_y    - signed QW-bit result
// Config : QUPD_SATURATE_EN defined -> reduction clamps, else truncates.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_fx_mul
  import q_pkg::*;
(
  input  q_t    i_x,
  input  coef_t i_coef,
  output q_t    o_y
);

  localparam int PW = QW + CW;

  logic signed [PW-1:0] w_x_ext;
  logic signed [PW-1:0] w_c_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;

  // The coefficient is zero-extended so the signed multiply treats it as
  // a non-negative value; the true product always fits in PW bits.
  assign w_x_ext = {{CW{i_x[QW-1]}}, i_x};
  assign w_c_ext = {{QW{1'b0}}, i_coef};
  assign w_prod  = w_x_ext * w_c_ext;
  assign w_shift = w_prod >>> FRAC;

`ifdef QUPD_SATURATE_EN
  logic w_in_range;
  // Fits in QW bits when every bit above the QW-1 sign bit matches it.
  assign w_in_range = (w_shift[PW-1:QW-1] == {(PW-QW+1){1'b0}}) ||
                      (w_shift[PW-1:QW-1] == {(PW-QW+1){1'b1}});
  assign o_y = w_in_range    ? w_shift[QW-1:0] :
               w_shift[PW-1] ? Q_MIN : Q_MAX;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_shift[PW-1:QW];
  assign o_y = w_shift[QW-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/q_update.sv
// ============================================================================
// Module : q_update
// Brief  : Sequential Q-learning update stage. Owns the 36x4 Q-table and
//          applies Q[s][a] <- Q[s][a] + alpha*(r + gamma*maxQ - Q[s][a])
//          over a six-cycle handshaked datapath, one multiplier shared
//          between the TD and SCALE steps.
// Ports  : clk, rst          - clock, asynchronous active-high reset
//          upd_valid/ready   - request handshake
//          maze_state, action, reward, max_Q, learn_rate, discount_factor
//                            - request operands, latched at acceptance
//          old_Q             - registered Q-table, read by max-Q stage
//          new_Q             - last value written
//          done / err        - one-cycle pulses: write completed / rejected
// Config : QUPD_SATURATE_EN defined -> saturating arithmetic, else wrap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_update
  import q_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [5:0] maze_state,
  input  logic [2:0] action,
  input  logic [3:0] reward,
  input  q_t         max_Q,
  input  coef_t      learn_rate,
  input  coef_t      discount_factor,
  output q_t         old_Q [N_STATES][N_ACTIONS],
  output q_t         new_Q,
  output logic       done,
  output logic       err
);

  q_state_e r_state;
  q_state_e w_state_nxt;

  logic [5:0] r_s;
  logic [1:0] r_a;
  logic [3:0] r_reward;
  q_t         r_max_q;
  coef_t      r_alpha;
  coef_t      r_gamma;
  q_t         r_q_old;
  q_t         r_target;
  q_t         r_delta;
  q_t         r_step;
  q_t         r_new_q;
  logic       r_done;
  logic       r_err;
  q_t         r_table [N_STATES][N_ACTIONS];

  logic  w_req_ok;
  logic  w_accept;
  q_t    w_mul_x;
  coef_t w_mul_c;
  q_t    w_mul_y;
  q_t    w_reward_fx;
  q_t    w_wr_val;

  assign w_req_ok = (maze_state <= 6'(N_STATES - 1)) &&
                    (action != 3'd0) && (action <= 3'(N_ACTIONS));
  assign w_accept = upd_valid && (r_state == ST_IDLE);

  // The single multiplier serves gamma*maxQ in TD and alpha*delta in SCALE.
  assign w_mul_x = (r_state == ST_TD) ? r_max_q : r_delta;
  assign w_mul_c = (r_state == ST_TD) ? r_gamma : r_alpha;

  q_fx_mul u_mul (
    .i_x    (w_mul_x),
    .i_coef (w_mul_c),
    .o_y    (w_mul_y)
  );

  assign w_reward_fx = {{(QW-4-FRAC){1'b0}}, r_reward, {FRAC{1'b0}}};
  assign w_wr_val    = q_add(r_q_old, r_step);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (upd_valid && w_req_ok) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_TD;
      ST_TD:    w_state_nxt = ST_DELTA;
      ST_DELTA: w_state_nxt = ST_SCALE;
      ST_SCALE: w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request capture and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s      <= '0;
      r_a      <= '0;
      r_reward <= '0;
      r_max_q  <= '0;
      r_alpha  <= '0;
      r_gamma  <= '0;
      r_q_old  <= '0;
      r_target <= '0;
      r_delta  <= '0;
      r_step   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_req_ok) begin
            r_s      <= maze_state;
            r_a      <= 2'(action - 3'd1);
            r_reward <= reward;
            r_max_q  <= max_Q;
            r_alpha  <= learn_rate;
            r_gamma  <= discount_factor;
          end
        end
        ST_READ:  r_q_old  <= r_table[r_s][r_a];
        ST_TD:    r_target <= q_add(w_reward_fx, w_mul_y);
        ST_DELTA: r_delta  <= q_sub(r_target, r_q_old);
        ST_SCALE: r_step   <= w_mul_y;
        default: ;
      endcase
    end
  end

  // Q-table, result register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_STATES; s++)
        for (int a = 0; a < N_ACTIONS; a++)
          r_table[s][a] <= '0;
      r_new_q <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_accept && !w_req_ok;
      if (r_state == ST_WRITE) begin
        r_table[r_s][r_a] <= w_wr_val;
        r_new_q           <= w_wr_val;
        r_done            <= 1'b1;
      end
    end
  end

  assign upd_ready = (r_state == ST_IDLE);
  assign old_Q     = r_table;
  assign new_Q     = r_new_q;
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire
